// File: rtl/currctrl_reset_sequencer_if.sv
// Avalon-MM slave bus used to program the current-control reset sequencer.
// Read data is combinational from the address, with zero wait states.
interface currctrl_reset_sequencer_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/currctrl_reset_sequencer.sv
// Sequenced reset controller for the current-control subsystem: software, fault and
// watchdog triggers assert every stage reset, hold them, then release stages in order.
module currctrl_reset_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 16,
  parameter int DEF_HOLD   = 1000,
  parameter int DEF_GAP    = 100,
  parameter int WDOG_W     = 24
) (
  input  logic                         clk,
  input  logic                         reset_n,
  currctrl_reset_sequencer_if.slave    avs,
  input  logic                         fault_in,
  output logic [NUM_STAGES-1:0]        rst_stage,
  output logic                         busy,
  output logic                         irq
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic                  wr;
  logic                  ctrl_wr;
  logic                  status_wr;
  logic                  kick;
  logic                  sw_trig;
  logic                  fault_trig;
  logic                  wdog_trig;
  logic                  trig;
  logic                  wdog_en;
  logic                  fault_en;
  logic                  irq_en;
  logic                  wdog_en_rise;
  logic [2:0]            cause;
  logic [2:0]            cause_clr;
  logic                  count_clr;
  logic [7:0]            trig_count;
  logic [CNT_W-1:0]      hold_reg;
  logic [CNT_W-1:0]      gap_reg;
  logic [CNT_W-1:0]      hold_load;
  logic [CNT_W-1:0]      gap_load;
  logic [CNT_W-1:0]      cnt;
  logic                  cnt_last;
  logic [WDOG_W-1:0]     wdog_load;
  logic [WDOG_W-1:0]     wdog_cnt;
  logic [1:0]            state;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] stage_q;
  logic                  seq_done;
  logic                  fault_s1;
  logic                  fault_s2;
  logic                  fault_s3;
  logic                  fault_rise;
  logic                  unused_wdata;

  assign wr        = avs.chipselect & ~avs.write_n;
  assign ctrl_wr   = wr && (avs.address == 3'd0);
  assign status_wr = wr && (avs.address == 3'd1);
  assign kick      = wr && (avs.address == 3'd5);

  assign cause_clr = status_wr ? avs.writedata[3:1] : 3'b000;
  assign count_clr = status_wr & avs.writedata[31];

  // Upper write-data bits only matter for some registers; fold them so none dangle.
  assign unused_wdata = ^avs.writedata;

  // A zero HOLD or GAP still costs one cycle so the sequence always advances.
  assign hold_load = (hold_reg == '0) ? CNT_W'(1) : hold_reg;
  assign gap_load  = (gap_reg == '0) ? CNT_W'(1) : gap_reg;
  assign cnt_last  = (cnt <= CNT_W'(1));

  assign sw_trig      = ctrl_wr & avs.writedata[0];
  assign wdog_en_rise = ctrl_wr & avs.writedata[1] & ~wdog_en;
  assign fault_rise   = fault_s2 & ~fault_s3;
  assign fault_trig   = fault_en & fault_rise;
  assign wdog_trig    = (state == ST_IDLE) && wdog_en && (wdog_cnt == '0) && !kick;
  assign trig         = sw_trig | fault_trig | wdog_trig;

  assign seq_done = (state == ST_RELEASE) && cnt_last && (idx == LAST_IDX) && !trig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fault_s1 <= 1'b0;
      fault_s2 <= 1'b0;
      fault_s3 <= 1'b0;
    end else begin
      fault_s1 <= fault_in;
      fault_s2 <= fault_s1;
      fault_s3 <= fault_s2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_en   <= 1'b0;
      fault_en  <= 1'b0;
      irq_en    <= 1'b0;
      hold_reg  <= CNT_W'(DEF_HOLD);
      gap_reg   <= CNT_W'(DEF_GAP);
      wdog_load <= '1;
    end else begin
      if (ctrl_wr) begin
        wdog_en  <= avs.writedata[1];
        fault_en <= avs.writedata[2];
        irq_en   <= avs.writedata[3];
      end
      if (wr && (avs.address == 3'd2)) hold_reg  <= avs.writedata[CNT_W-1:0];
      if (wr && (avs.address == 3'd3)) gap_reg   <= avs.writedata[CNT_W-1:0];
      if (wr && (avs.address == 3'd4)) wdog_load <= avs.writedata[WDOG_W-1:0];
    end
  end

  // New cause bits take priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause      <= 3'b000;
      trig_count <= 8'd0;
    end else begin
      cause <= (cause & ~cause_clr) | {wdog_trig, fault_trig, sw_trig};
      if (count_clr) begin
        trig_count <= trig ? 8'd1 : 8'd0;
      end else if (trig && (trig_count != 8'hFF)) begin
        trig_count <= trig_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt <= '1;
    end else if (kick || wdog_en_rise || seq_done) begin
      wdog_cnt <= wdog_load;
    end else if ((state == ST_IDLE) && wdog_en && (wdog_cnt != '0)) begin
      wdog_cnt <= wdog_cnt - WDOG_W'(1);
    end
  end

  // Any trigger, in any state, reasserts every stage and restarts the hold period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_ASSERT;
      cnt     <= CNT_W'(DEF_HOLD);
      idx     <= '0;
      stage_q <= '1;
    end else if (trig) begin
      state   <= ST_ASSERT;
      cnt     <= hold_load;
      idx     <= '0;
      stage_q <= '1;
    end else begin
      case (state)
        ST_ASSERT: begin
          if (cnt_last) begin
            state <= ST_RELEASE;
            cnt   <= gap_load;
            idx   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_last) begin
            stage_q[idx] <= 1'b0;
            if (idx == LAST_IDX) begin
              state <= ST_IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
              cnt <= gap_load;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          stage_q <= '0;
        end
      endcase
    end
  end

  assign rst_stage = stage_q;
  assign busy      = (state != ST_IDLE);
  assign irq       = (|cause) & irq_en;

  always_comb begin
    avs.readdata = 32'd0;
    case (avs.address)
      3'd0:    avs.readdata = {28'd0, irq_en, fault_en, wdog_en, 1'b0};
      3'd1:    avs.readdata = {16'd0, trig_count, 4'd0, cause, busy};
      3'd2:    avs.readdata = 32'(hold_reg);
      3'd3:    avs.readdata = 32'(gap_reg);
      3'd4:    avs.readdata = 32'(wdog_load);
      default: avs.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_currctrl_reset_sequencer.sv
// Directed plus randomized bench for currctrl_reset_sequencer; expected stage timing,
// cause bits and trigger count come from a small behavioural model of the register map.
module tb_currctrl_reset_sequencer;
  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          fault_in = 1'b0;
  logic [NS-1:0] rst_stage;
  logic          busy;
  logic          irq;

  int total = 0;
  int bad = 0;

  logic [2:0] ctrl_m;
  logic [2:0] cause_m;
  int         count_m;
  int         hold_m;
  int         gap_m;
  logic [31:0] rd;

  currctrl_reset_sequencer_if bus ();

  currctrl_reset_sequencer #(
    .NUM_STAGES(NS),
    .CNT_W(16),
    .DEF_HOLD(1000),
    .DEF_GAP(100),
    .WDOG_W(24)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .avs(bus),
    .fault_in(fault_in),
    .rst_stage(rst_stage),
    .busy(busy),
    .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelTrigger(input logic [2:0] src);
    cause_m = cause_m | src;
    if (count_m < 255) count_m++;
  endtask

  task automatic modelReset();
    ctrl_m = 3'b000;
    cause_m = 3'b000;
    count_m = 0;
    hold_m = 1000;
    gap_m = 100;
  endtask

  // One-cycle bus write, started and finished on a falling clock edge.
  task automatic applyStimulus(input logic [2:0] a, input logic [31:0] d);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    bus.writedata = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'd0;
    case (a)
      3'd0: begin
        ctrl_m = d[3:1];
        if (d[0]) modelTrigger(3'b001);
      end
      3'd1: begin
        cause_m = cause_m & ~d[3:1];
        if (d[31]) count_m = 0;
      end
      3'd2: hold_m = int'(d[15:0]);
      3'd3: gap_m = int'(d[15:0]);
      default: ;
    endcase
  endtask

  task automatic readReg(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b1;
    #1;
    d = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkStatus(input string tag, input logic b);
    logic [31:0] d;
    readReg(3'd1, d);
    checkOutput(tag, d, {16'd0, 8'(count_m), 4'd0, cause_m, b});
  endtask

  task automatic checkIrq(input string tag);
    checkOutput(tag, 32'(irq), 32'((|cause_m) & ctrl_m[2]));
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(busy), 32'd0);
  endtask

  // Called on the falling edge right after rst_stage first goes high (t = 0).
  task automatic runSequence(input string tag);
    int he, ge, span;
    logic [31:0] e;
    he = (hold_m < 1) ? 1 : hold_m;
    ge = (gap_m < 1) ? 1 : gap_m;
    span = he + NS * ge;
    for (int t = 0; t <= span; t++) begin
      if (t > 0) @(negedge clk);
      e = 32'd0;
      for (int k = 0; k < NS; k++) if (t < he + (k + 1) * ge) e[k] = 1'b1;
      checkOutput({tag, "_stage"}, 32'(rst_stage), e);
      checkOutput({tag, "_busy"}, 32'(busy), (t < span) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int h, g;
    logic [31:0] cw, e;
    bus.address = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = 32'd0;
    modelReset();

    // Reset state
    waitCycles(3);
    checkOutput("rst_stage_reset", 32'(rst_stage), 32'h7);
    checkOutput("busy_reset", 32'(busy), 32'd1);
    checkOutput("irq_reset", 32'(irq), 32'd0);
    readReg(3'd0, rd); checkOutput("ctrl_reset", rd, 32'd0);
    checkStatus("status_reset", 1'b1);
    readReg(3'd2, rd); checkOutput("hold_reset", rd, 32'd1000);
    readReg(3'd3, rd); checkOutput("gap_reset", rd, 32'd100);
    readReg(3'd4, rd); checkOutput("wdog_load_reset", rd, 32'h00FF_FFFF);
    readReg(3'd6, rd); checkOutput("unmapped_read", rd, 32'd0);

    // Power-on sequence with default HOLD/GAP
    @(negedge clk);
    reset_n = 1'b1;
    runSequence("poweron");
    checkStatus("status_poweron", 1'b0);

    // Software trigger with HOLD=4 GAP=2
    applyStimulus(3'd2, 32'd4);
    applyStimulus(3'd3, 32'd2);
    applyStimulus(3'd7, 32'hFFFF_FFFF);
    applyStimulus(3'd0, 32'd1);
    runSequence("sw");
    checkStatus("status_sw", 1'b0);
    readReg(3'd0, rd); checkOutput("ctrl_sw_reads0", rd, 32'd0);

    // Randomized HOLD/GAP (including zero) and CTRL enables
    for (int i = 0; i < 5; i++) begin
      h = $urandom_range(0, 10);
      g = $urandom_range(0, 5);
      cw = {28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b01};
      applyStimulus(3'd2, 32'(h));
      applyStimulus(3'd3, 32'(g));
      readReg(3'd2, rd); checkOutput("hold_rb", rd, 32'(h));
      readReg(3'd3, rd); checkOutput("gap_rb", rd, 32'(g));
      applyStimulus(3'd0, cw);
      runSequence("rand");
      checkStatus("status_rand", 1'b0);
      checkIrq("irq_rand");
      readReg(3'd0, rd); checkOutput("ctrl_rand", rd, {28'd0, ctrl_m, 1'b0});
    end

    // Fault trigger: three clocks from the fault_in edge to all stages high
    applyStimulus(3'd2, 32'd4);
    applyStimulus(3'd3, 32'd2);
    applyStimulus(3'd1, 32'hE);
    applyStimulus(3'd0, 32'hC);
    checkIrq("irq_cleared");
    fault_in = 1'b1;
    @(negedge clk);
    checkOutput("fault_lat1", 32'(rst_stage), 32'd0);
    @(negedge clk);
    checkOutput("fault_lat2", 32'(rst_stage), 32'd0);
    @(negedge clk);
    modelTrigger(3'b010);
    runSequence("fault");
    fault_in = 1'b0;
    checkStatus("status_fault", 1'b0);
    checkIrq("irq_fault_en");
    applyStimulus(3'd0, 32'h4);
    checkIrq("irq_fault_masked");
    applyStimulus(3'd0, 32'hC);
    checkIrq("irq_fault_unmasked");
    applyStimulus(3'd1, 32'h4);
    checkIrq("irq_after_w1c");
    checkStatus("status_after_w1c", 1'b0);

    // fault_en=0 ignores the fault
    applyStimulus(3'd0, 32'h8);
    fault_in = 1'b1;
    waitCycles(10);
    checkOutput("fault_dis_stage", 32'(rst_stage), 32'd0);
    checkOutput("fault_dis_busy", 32'(busy), 32'd0);
    fault_in = 1'b0;
    checkStatus("status_fault_dis", 1'b0);

    // Watchdog expiry with WDOG_LOAD=50
    applyStimulus(3'd4, 32'd50);
    applyStimulus(3'd0, 32'h2);
    waitCycles(50);
    checkOutput("wdog_before", 32'(rst_stage), 32'd0);
    @(negedge clk);
    modelTrigger(3'b100);
    runSequence("wdog");
    checkStatus("status_wdog", 1'b0);

    // Regular kicks keep the watchdog quiet
    for (int i = 0; i < 25; i++) begin
      waitCycles(39);
      applyStimulus(3'd5, 32'd0);
      checkOutput("kick_busy", 32'(busy), 32'd0);
    end
    checkStatus("status_kicked", 1'b0);

    // Kick in the expiry cycle wins
    waitCycles(50);
    applyStimulus(3'd5, 32'd0);
    checkOutput("kick_expiry_stage", 32'(rst_stage), 32'd0);
    waitCycles(2);
    checkOutput("kick_expiry_busy", 32'(busy), 32'd0);
    applyStimulus(3'd0, 32'd0);
    checkStatus("status_kick_expiry", 1'b0);

    // sw_req during RELEASE restarts the whole sequence
    applyStimulus(3'd0, 32'd1);
    for (int t = 1; t <= 7; t++) begin
      @(negedge clk);
      e = 32'd0;
      for (int k = 0; k < NS; k++) if (t < 4 + (k + 1) * 2) e[k] = 1'b1;
      checkOutput("pre_restart_stage", 32'(rst_stage), e);
    end
    applyStimulus(3'd0, 32'd1);
    runSequence("restart");
    checkStatus("status_restart", 1'b0);

    // Count saturation, then clear
    for (int i = 0; i < 300; i++) applyStimulus(3'd0, 32'd1);
    checkStatus("status_saturated", 1'b1);
    applyStimulus(3'd1, 32'h8000_0000);
    checkStatus("status_count_clr", 1'b1);

    // Count clear and cause clear coincident with a fault trigger
    applyStimulus(3'd0, 32'h4);
    fault_in = 1'b1;
    waitCycles(2);
    applyStimulus(3'd1, 32'h8000_0004);
    modelTrigger(3'b010);
    fault_in = 1'b0;
    checkStatus("status_clr_and_set", 1'b1);
    waitIdle("idle_after_clr_set", 200);

    // reset_n asserted mid-RELEASE
    applyStimulus(3'd0, 32'd1);
    waitCycles(7);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_stage", 32'(rst_stage), 32'h7);
    checkOutput("midrst_busy", 32'(busy), 32'd1);
    readReg(3'd0, rd); checkOutput("midrst_ctrl", rd, 32'd0);
    checkStatus("midrst_status", 1'b1);
    readReg(3'd2, rd); checkOutput("midrst_hold", rd, 32'd1000);
    @(negedge clk);
    reset_n = 1'b1;
    waitCycles(5);
    checkOutput("midrst_after", 32'(rst_stage), 32'h7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
